ats21_cmd_issuer: RTL and testbench

- Upstream command front-end for the ATS21 timer core.
- Accepts 32-bit instructions from two clients (A, B) over valid/ready and buffers each client in its own FIFO.
- Serialises each instruction onto the core's 16-bit ctrlA/ctrlB buses as top half then bottom half under req.
- Samples the core's per-client stat bits and returns an ack/nack response to each client, keeping saturating nack counters.

---
 rtl/ats21_cmd_issuer_if.sv | 20 ++
 rtl/ats21_cmd_issuer.sv | 117 +++++++++++
 tb/tb_ats21_cmd_issuer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ats21_cmd_issuer_if.sv
// ats21_cmd_issuer_if: client command, core request/status and response bundle
interface ats21_cmd_issuer_if #(parameter int CNT_W = 8);
    logic             cmd_valid_a, cmd_ready_a, cmd_valid_b, cmd_ready_b;
    logic [31:0]      cmd_a, cmd_b;
    logic             req;
    logic [15:0]      ctrlA, ctrlB;
    logic [1:0]       stat;
    logic             rsp_valid_a, rsp_ack_a, rsp_valid_b, rsp_ack_b, busy;
    logic [CNT_W-1:0] nack_cnt_a, nack_cnt_b;
    modport master (
        output cmd_valid_a, cmd_a, cmd_valid_b, cmd_b, stat,
        input  cmd_ready_a, cmd_ready_b, req, ctrlA, ctrlB, rsp_valid_a, rsp_ack_a,
               rsp_valid_b, rsp_ack_b, busy, nack_cnt_a, nack_cnt_b
    );
    modport slave (
        input  cmd_valid_a, cmd_a, cmd_valid_b, cmd_b, stat,
        output cmd_ready_a, cmd_ready_b, req, ctrlA, ctrlB, rsp_valid_a, rsp_ack_a,
               rsp_valid_b, rsp_ack_b, busy, nack_cnt_a, nack_cnt_b
    );
endinterface

// File: rtl/ats21_cmd_issuer.sv
// ats21_cmd_issuer: two-client FIFO front-end serialising 32-bit commands onto the
// ATS21 core's 16-bit lanes and returning ack/nack responses with nack counters.
module ats21_cmd_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int STAT_LAT   = 2,
    parameter int CNT_W      = 8
) (
    input logic clk,
    input logic reset,
    ats21_cmd_issuer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, TOP, BOT, WAIT, RESP} state_t;
    state_t           state, state_n;
    logic [3:0]       wcnt;
    logic             rdy_en, req_d;
    logic [1:0]       valid_in, ready, empty, full, push, pop, lane_vld, live, rv_d, ack_d;
    logic [31:0]      din [2];
    logic [31:0]      dout [2];
    logic [31:0]      issue [2];
    logic [15:0]      ctrl_d [2];
    logic [CNT_W-1:0] cnt [2];
    logic [CNT_W-1:0] cnt_d [2];

    assign valid_in        = {bus.cmd_valid_b, bus.cmd_valid_a};
    assign din[0]          = bus.cmd_a;
    assign din[1]          = bus.cmd_b;
    assign bus.cmd_ready_a = ready[0];
    assign bus.cmd_ready_b = ready[1];
    assign bus.nack_cnt_a  = cnt[0];
    assign bus.nack_cnt_b  = cnt[1];

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [31:0] mem [FIFO_DEPTH];
        logic [AW:0] wp, rp;
        assign empty[g]    = wp == rp;
        assign full[g]     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
        assign ready[g]    = rdy_en && !full[g];
        assign push[g]     = valid_in[g] && ready[g];
        assign pop[g]      = state == IDLE && !empty[g];
        assign dout[g]     = mem[rp[AW-1:0]];
        assign live[g]     = lane_vld[g] && |issue[g][31:29];
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push[g]) wp <= wp + 1'b1;
                if (pop[g]) rp <= rp + 1'b1;
            end
        always_ff @(posedge clk)
            if (push[g]) mem[wp[AW-1:0]] <= din[g];
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= IDLE;
            wcnt     <= '0;
            rdy_en   <= 1'b0;
            lane_vld <= '0;
            issue[0] <= '0;
            issue[1] <= '0;
        end else begin
            state  <= state_n;
            wcnt   <= state == WAIT ? wcnt + 4'd1 : 4'd0;
            rdy_en <= 1'b1;
            if (state == IDLE) begin
                lane_vld <= ~empty;
                issue[0] <= dout[0];
                issue[1] <= dout[1];
            end
        end

    always_comb
        state_n = state == IDLE ? (&empty ? IDLE : TOP) :
                  state == TOP  ? BOT :
                  state == BOT  ? WAIT :
                  state == WAIT ? (wcnt == 4'(STAT_LAT - 1) ? RESP : WAIT) : IDLE;

    // Opcode-000 commands keep their lane quiet and are acked without consulting stat
    always_comb begin
        req_d = state == TOP || state == BOT;
        for (int i = 0; i < 2; i++) begin
            ctrl_d[i] = !(req_d && live[i]) ? 16'h0000 :
                        state == TOP ? issue[i][31:16] : issue[i][15:0];
            rv_d[i]   = state == RESP && lane_vld[i];
            ack_d[i]  = rv_d[i] && (!live[i] || bus.stat[i]);
            cnt_d[i]  = rv_d[i] && !ack_d[i] && cnt[i] != '1 ? cnt[i] + 1'b1 : cnt[i];
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            bus.req         <= 1'b0;
            bus.ctrlA       <= '0;
            bus.ctrlB       <= '0;
            bus.rsp_valid_a <= 1'b0;
            bus.rsp_valid_b <= 1'b0;
            bus.rsp_ack_a   <= 1'b0;
            bus.rsp_ack_b   <= 1'b0;
            bus.busy        <= 1'b0;
            cnt[0]          <= '0;
            cnt[1]          <= '0;
        end else begin
            bus.req         <= req_d;
            bus.ctrlA       <= ctrl_d[0];
            bus.ctrlB       <= ctrl_d[1];
            bus.rsp_valid_a <= rv_d[0];
            bus.rsp_valid_b <= rv_d[1];
            bus.rsp_ack_a   <= ack_d[0];
            bus.rsp_ack_b   <= ack_d[1];
            bus.busy        <= state_n != IDLE;
            cnt[0]          <= cnt_d[0];
            cnt[1]          <= cnt_d[1];
        end
endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// tb_ats21_cmd_issuer: directed bench for the ATS21 command issuer.
module tb_ats21_cmd_issuer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    logic seen;

    ats21_cmd_issuer_if bus();
    ats21_cmd_issuer dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one command per lane for exactly one rising edge (edge 0); returns in cycle 0
    task automatic push(input logic va, input logic [31:0] a, input logic vb, input logic [31:0] b);
        bus.cmd_valid_a = va;
        bus.cmd_a       = a;
        bus.cmd_valid_b = vb;
        bus.cmd_b       = b;
        @(negedge clk);
        bus.cmd_valid_a = 1'b0;
        bus.cmd_valid_b = 1'b0;
    endtask

    initial begin
        bus.cmd_valid_a = 1'b0;
        bus.cmd_valid_b = 1'b0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.stat        = 2'b00;
        cyc(2);
        chk("rst_req", bus.req, 0);
        chk("rst_ready_a", bus.cmd_ready_a, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_nack_a", bus.nack_cnt_a, 0);
        reset = 1'b1;
        cyc(1);
        chk("post_rst_ready_a", bus.cmd_ready_a, 1);
        chk("post_rst_ready_b", bus.cmd_ready_b, 1);

        // Reset asserted while the top half is on the bus
        bus.stat = 2'b01;
        push(1'b1, 32'h2A40_0010, 1'b0, 32'h0);
        cyc(2);
        chk("t1_top_ctrlA", bus.ctrlA, 32'h2A40);
        #2 reset = 1'b0;
        #1;
        chk("t1_async_req", bus.req, 0);
        chk("t1_async_ctrlA", bus.ctrlA, 0);
        cyc(1);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            seen = seen | bus.rsp_valid_a;
        end
        chk("t1_no_rsp", seen, 0);
        chk("t1_ready_a", bus.cmd_ready_a, 1);
        chk("t1_busy", bus.busy, 0);

        // Single client-A command
        bus.stat = 2'b01;
        push(1'b1, 32'h2A40_0010, 1'b0, 32'h0);
        cyc(2);
        chk("t2_top_req", bus.req, 1);
        chk("t2_top_ctrlA", bus.ctrlA, 32'h2A40);
        chk("t2_top_ctrlB", bus.ctrlB, 0);
        chk("t2_busy", bus.busy, 1);
        cyc(1);
        chk("t2_bot_ctrlA", bus.ctrlA, 32'h0010);
        chk("t2_bot_req", bus.req, 1);
        cyc(1);
        chk("t2_wait_req", bus.req, 0);
        chk("t2_wait_ctrlA", bus.ctrlA, 0);
        cyc(1);
        chk("t2_early_rsp", bus.rsp_valid_a, 0);
        cyc(1);
        chk("t2_rsp_valid_a", bus.rsp_valid_a, 1);
        chk("t2_rsp_ack_a", bus.rsp_ack_a, 1);
        chk("t2_rsp_valid_b", bus.rsp_valid_b, 0);
        chk("t2_nack_a", bus.nack_cnt_a, 0);
        cyc(1);
        chk("t2_rsp_pulse_end", bus.rsp_valid_a, 0);
        chk("t2_idle", bus.busy, 0);

        // Both lanes in one transaction, A nacked
        bus.stat = 2'b10;
        push(1'b1, 32'hA300_0100, 1'b1, 32'hC500_0020);
        cyc(2);
        chk("t3_top_ctrlA", bus.ctrlA, 32'hA300);
        chk("t3_top_ctrlB", bus.ctrlB, 32'hC500);
        cyc(1);
        chk("t3_bot_ctrlA", bus.ctrlA, 32'h0100);
        chk("t3_bot_ctrlB", bus.ctrlB, 32'h0020);
        cyc(3);
        chk("t3_rsp_valid_a", bus.rsp_valid_a, 1);
        chk("t3_rsp_valid_b", bus.rsp_valid_b, 1);
        chk("t3_rsp_ack_a", bus.rsp_ack_a, 0);
        chk("t3_rsp_ack_b", bus.rsp_ack_b, 1);
        chk("t3_nack_a", bus.nack_cnt_a, 1);
        chk("t3_nack_b", bus.nack_cnt_b, 0);
        cyc(2);

        // Fill FIFO A while a B transaction keeps the FSM busy
        bus.stat = 2'b11;
        bus.cmd_valid_b = 1'b1;
        bus.cmd_b = 32'h3000_0001;
        cyc(1);
        bus.cmd_valid_b = 1'b0;
        bus.cmd_valid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.cmd_a = {16'h2100 + 16'(i), 16'(i)};
            if (i == 3) chk("t4_ready_3", bus.cmd_ready_a, 1);
            cyc(1);
        end
        chk("t4_full_ready", bus.cmd_ready_a, 0);
        bus.cmd_a = 32'h2104_0004;
        cyc(1);
        chk("t4_held_off", bus.cmd_ready_a, 0);
        cyc(2);
        chk("t4_ready_again", bus.cmd_ready_a, 1);
        cyc(1);
        bus.cmd_valid_a = 1'b0;
        chk("t4_top0", bus.ctrlA, 32'h2100);
        for (int i = 1; i < 5; i++) begin
            cyc(5);
            chk("t4_gap_req", bus.req, 0);
            cyc(1);
            chk("t4_top_order", bus.ctrlA, 32'h2100 + i);
        end
        cyc(6);

        // Opcode-000 on B stays off the bus and is acked regardless of stat
        bus.stat = 2'b00;
        push(1'b0, 32'h0, 1'b1, 32'h0000_1234);
        cyc(2);
        chk("t5_top_req", bus.req, 1);
        chk("t5_top_ctrlB", bus.ctrlB, 0);
        cyc(1);
        chk("t5_bot_ctrlB", bus.ctrlB, 0);
        cyc(3);
        chk("t5_rsp_valid_b", bus.rsp_valid_b, 1);
        chk("t5_rsp_ack_b", bus.rsp_ack_b, 1);
        chk("t5_nack_b", bus.nack_cnt_b, 0);
        cyc(2);

        // Saturation of the A nack counter (already 1 from the dual-lane step)
        bus.stat = 2'b00;
        bus.cmd_valid_a = 1'b1;
        bus.cmd_a = 32'h2000_0000;
        for (int i = 0; i < 2200 && pulses < 300; i++) begin
            cyc(1);
            if (bus.rsp_valid_a) begin
                pulses++;
                if (pulses == 100) chk("t6_cnt_mid", bus.nack_cnt_a, 32'h65);
                if (pulses == 254) chk("t6_cnt_sat", bus.nack_cnt_a, 32'hFF);
                if (pulses == 260) chk("t6_ack_low", bus.rsp_ack_a, 0);
            end
        end
        bus.cmd_valid_a = 1'b0;
        chk("t6_pulses", pulses, 300);
        chk("t6_no_wrap", bus.nack_cnt_a, 32'hFF);
        cyc(40);
        chk("t6_final_cnt", bus.nack_cnt_a, 32'hFF);
        chk("t6_final_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
